// File: rtl/exwb_writeback_stage.sv
// exwb_writeback_stage: EX/WB pipeline register, 8x8 register file commit and
// combinational ID read ports with write-through of the committing entry.
module exwb_writeback_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic [ADDR_WIDTH-1:0] WriteRegister_EX,
    input  logic [DATA_WIDTH-1:0] WriteData_EX,
    input  logic                  WriteSignal_EX,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1_ID,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2_ID,
    output logic [DATA_WIDTH-1:0] ReadData1_ID,
    output logic [DATA_WIDTH-1:0] ReadData2_ID,
    output logic [ADDR_WIDTH-1:0] WriteRegister_EXWB,
    output logic [DATA_WIDTH-1:0] WriteData_EXWB,
    output logic                  WriteSignal_EXWB,
    output logic [7:0]            RetireCount
);
    localparam int NREG = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wr_q, wr_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic                  ws_q, ws_d;
    logic [7:0]            cnt_q;
    logic [DATA_WIDTH-1:0] rf_q [NREG];
    logic                  commit;

    // A held entry commits once, when the stall releases or a flush pushes it out.
    assign commit = ws_q & (~Stall | Flush);

    always_comb begin
        wr_d = Flush ? '0   : Stall ? wr_q : WriteRegister_EX;
        wd_d = Flush ? '0   : Stall ? wd_q : WriteData_EX;
        ws_d = Flush ? 1'b0 : Stall ? ws_q : WriteSignal_EX;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            wd_q  <= '0;
            ws_q  <= 1'b0;
            cnt_q <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            wr_q <= wr_d;
            wd_q <= wd_d;
            ws_q <= ws_d;
            if (commit) begin
                rf_q[wr_q] <= wd_q;
                cnt_q      <= cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        ReadData1_ID = (commit && ReadRegister1_ID == wr_q) ? wd_q : rf_q[ReadRegister1_ID];
        ReadData2_ID = (commit && ReadRegister2_ID == wr_q) ? wd_q : rf_q[ReadRegister2_ID];
    end

    assign WriteRegister_EXWB = wr_q;
    assign WriteData_EXWB     = wd_q;
    assign WriteSignal_EXWB   = ws_q;
    assign RetireCount        = cnt_q;
endmodule

// File: tb/tb_exwb_writeback_stage.sv
// tb_exwb_writeback_stage: directed vectors with a queued scoreboard; a negedge
// monitor pops every expectation queued for the current cycle and compares.
module tb_exwb_writeback_stage;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Stall = 1'b0, Flush = 1'b0;
    logic [2:0] WriteRegister_EX = '0;
    logic [7:0] WriteData_EX = '0;
    logic       WriteSignal_EX = 1'b0;
    logic [2:0] ReadRegister1_ID = '0, ReadRegister2_ID = '0;
    logic [7:0] ReadData1_ID, ReadData2_ID;
    logic [2:0] WriteRegister_EXWB;
    logic [7:0] WriteData_EXWB;
    logic       WriteSignal_EXWB;
    logic [7:0] RetireCount;

    exwb_writeback_stage dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
        .WriteRegister_EX(WriteRegister_EX), .WriteData_EX(WriteData_EX),
        .WriteSignal_EX(WriteSignal_EX),
        .ReadRegister1_ID(ReadRegister1_ID), .ReadRegister2_ID(ReadRegister2_ID),
        .ReadData1_ID(ReadData1_ID), .ReadData2_ID(ReadData2_ID),
        .WriteRegister_EXWB(WriteRegister_EXWB), .WriteData_EXWB(WriteData_EXWB),
        .WriteSignal_EXWB(WriteSignal_EXWB), .RetireCount(RetireCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [7:0] exp;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            0:       return {5'b0, WriteRegister_EXWB};
            1:       return WriteData_EXWB;
            2:       return {7'b0, WriteSignal_EXWB};
            3:       return RetireCount;
            4:       return ReadData1_ID;
            default: return ReadData2_ID;
        endcase
    endfunction

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = sb.pop_front();
            act = observe(e.sel);
            nvec++;
            if (act !== e.exp) begin
                nerr++;
                $display("FAIL %s: got %h want %h at %0t", e.nm, act, e.exp, $time);
            end
        end
    end

    task automatic expect_v(input int sel, input logic [7:0] v, input string nm);
        sb.push_back('{sel, v, nm});
    endtask

    task automatic expect_exwb(input logic [2:0] wr, input logic [7:0] wd, input logic ws, input string nm);
        expect_v(0, {5'b0, wr}, {nm, ".wr"});
        expect_v(1, wd, {nm, ".wd"});
        expect_v(2, {7'b0, ws}, {nm, ".ws"});
    endtask

    task automatic cyc(input logic st, input logic fl, input logic [2:0] wr, input logic [7:0] wd,
                       input logic ws, input logic [2:0] r1, input logic [2:0] r2);
        @(posedge clk);
        #1;
        Stall = st; Flush = fl;
        WriteRegister_EX = wr; WriteData_EX = wd; WriteSignal_EX = ws;
        ReadRegister1_ID = r1; ReadRegister2_ID = r2;
    endtask

    initial begin
        // Reset asserted before any clock edge: outputs must clear asynchronously.
        #2 reset = 1'b1;
        expect_exwb(3'd0, 8'h00, 1'b0, "rst_async");
        expect_v(3, 8'h00, "rst_async.cnt");
        for (int i = 0; i < 8; i += 2) begin
            cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'(i), 3'(i + 1));
            expect_v(4, 8'h00, $sformatf("rst_read_R%0d", i));
            expect_v(5, 8'h00, $sformatf("rst_read_R%0d", i + 1));
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 3'(i), 8'(i * 17), 1'b0, 3'd0, 3'd0);
            expect_v(3, 8'h00, $sformatf("idle_cnt%0d", i));
        end
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
        expect_v(2, 8'h00, "idle_tail.ws");

        // Basic write-back.
        cyc(1'b0, 1'b0, 3'd3, 8'hA5, 1'b1, 3'd3, 3'd0);
        expect_v(4, 8'h00, "basicN.rd1");
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd3);
        expect_exwb(3'd3, 8'hA5, 1'b1, "basicN1");
        expect_v(4, 8'hA5, "basicN1.wt1");
        expect_v(5, 8'hA5, "basicN1.wt2");
        expect_v(3, 8'h00, "basicN1.cnt");
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd0);
        expect_v(4, 8'hA5, "basicN2.rd1");
        expect_v(2, 8'h00, "basicN2.ws");
        expect_v(3, 8'h01, "basicN2.cnt");

        // Stall for three cycles; EX inputs during stall must be ignored.
        cyc(1'b0, 1'b0, 3'd5, 8'h3C, 1'b1, 3'd5, 3'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 3'd7, 8'hFF, 1'b1, 3'd5, 3'd0);
            expect_exwb(3'd5, 8'h3C, 1'b1, $sformatf("stall%0d", k));
            expect_v(4, 8'h00, $sformatf("stall%0d.rd1", k));
            expect_v(3, 8'h01, $sformatf("stall%0d.cnt", k));
        end
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd0);
        expect_exwb(3'd5, 8'h3C, 1'b1, "stall_rel");
        expect_v(4, 8'h3C, "stall_rel.wt1");
        expect_v(3, 8'h01, "stall_rel.cnt");
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd0);
        expect_v(4, 8'h3C, "stall_done.rd1");
        expect_v(3, 8'h02, "stall_done.cnt");
        expect_v(2, 8'h00, "stall_done.ws");

        // Flush together with Stall: old entry commits, bubble loads.
        cyc(1'b0, 1'b0, 3'd2, 8'h11, 1'b1, 3'd2, 3'd2);
        cyc(1'b1, 1'b1, 3'd4, 8'h99, 1'b1, 3'd2, 3'd4);
        expect_exwb(3'd2, 8'h11, 1'b1, "flush_edge");
        expect_v(4, 8'h11, "flush_edge.wt1");
        expect_v(5, 8'h00, "flush_edge.rd2");
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 3'd4);
        expect_exwb(3'd0, 8'h00, 1'b0, "flush_bubble");
        expect_v(4, 8'h11, "flush_bubble.rd1");
        expect_v(5, 8'h00, "flush_bubble.rd2");
        expect_v(3, 8'h03, "flush_bubble.cnt");

        // Bubble with nonzero address/data: no write, no write-through.
        cyc(1'b0, 1'b0, 3'd2, 8'hEE, 1'b0, 3'd2, 3'd2);
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 3'd2);
        expect_v(4, 8'h11, "bubble.rd1");
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 3'd2);
        expect_v(5, 8'h11, "bubble_after.rd2");
        expect_v(3, 8'h03, "bubble_after.cnt");

        // Reset pulse, then 256 back-to-back writes to R1 to wrap the counter.
        @(posedge clk);
        #1 reset = 1'b1;
        expect_v(3, 8'h00, "rst2.cnt");
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 256; i++) cyc(1'b0, 1'b0, 3'd1, 8'(i), 1'b1, 3'd1, 3'd0);
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd1);
        expect_exwb(3'd1, 8'hFF, 1'b1, "wrap_last");
        expect_v(3, 8'hFF, "wrap_last.cnt");
        expect_v(5, 8'hFF, "wrap_last.wt2");
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd1);
        expect_v(3, 8'h00, "wrap.cnt");
        expect_v(4, 8'hFF, "wrap.rd1");

        // Reset before the commit edge discards the pending R6 write.
        cyc(1'b0, 1'b0, 3'd6, 8'h77, 1'b1, 3'd6, 3'd0);
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd6, 3'd1);
        #1 reset = 1'b1;
        expect_exwb(3'd0, 8'h00, 1'b0, "rst_mid");
        expect_v(3, 8'h00, "rst_mid.cnt");
        expect_v(4, 8'h00, "rst_mid.rd1");
        expect_v(5, 8'h00, "rst_mid.rd2");
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd6, 3'd1);
        expect_v(4, 8'h00, "rst_mid_after.R6");
        expect_v(5, 8'h00, "rst_mid_after.R1");
        expect_v(3, 8'h00, "rst_mid_after.cnt");
        expect_v(2, 8'h00, "rst_mid_after.ws");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
